serial_add_sub: RTL and testbench



---
 rtl/serial_add_sub.sv | 146 ++++++++++++++
 tb/tb_serial_add_sub.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// serial_add_sub: digit-serial two's-complement adder/subtractor.
// Processes DIGIT bits per clock over NDIG = WIDTH/DIGIT cycles using a single
// DIGIT-wide adder slice. Result and flags are held between done pulses.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      request, sampled only while ready=1
//   mode       0 = add (a+b), 1 = subtract (a+~b+1)
//   a, b       operands, captured on an accepted start
//   ready      high when a start will be accepted
//   done       one-cycle pulse when result/flags update
//   result     sum/difference, held until the next done
//   c_out      carry out of the MSB (subtract: 1 = no borrow)
//   over_flow  signed overflow
//   zero       result == 0
//   neg        result MSB
//
// Optional build macro: SERIAL_ADD_SUB_SAT_EN clamps the result to the most
// positive/negative value on signed overflow instead of wrapping.
// WIDTH must be a multiple of DIGIT and at least 2*DIGIT.

module serial_add_sub #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             c_out,
   output logic             over_flow,
   output logic             zero,
   output logic             neg
);

   localparam int unsigned NDIG  = WIDTH / DIGIT;
   localparam int unsigned CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t                 r_state;
   logic [WIDTH-1:0]       r_a;
   logic [WIDTH-1:0]       r_b;
   logic [WIDTH-DIGIT-1:0] r_part;
   logic                   r_carry;
   logic [CNT_W-1:0]       r_cnt;
   logic                   r_ready;
   logic                   r_done;
   logic [WIDTH-1:0]       r_result;
   logic                   r_c_out;
   logic                   r_ovf;
   logic                   r_zero;
   logic                   r_neg;

   logic [DIGIT:0]         w_sum;
   logic [WIDTH-1:0]       w_res_wrap;
   logic [WIDTH-1:0]       w_res;
   logic                   w_ovf;
   logic                   w_last;

   // Shared digit slice: operands shift right so the active digit is always at the bottom.
   assign w_sum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + (DIGIT+1)'(r_carry);

   // Partial result enters from the top; on the final digit this is the full word.
   assign w_res_wrap = {w_sum[DIGIT-1:0], r_part};

   // Carry into the MSB is recovered from the MSB sum bit and the operand MSBs.
   assign w_ovf = w_sum[DIGIT] ^ (r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_sum[DIGIT-1]);

`ifdef SERIAL_ADD_SUB_SAT_EN
   // Clamp direction follows the sign of A, which overflow shares with the true result.
   assign w_res = !w_ovf       ? w_res_wrap :
                  r_a[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                 {1'b0, {(WIDTH-1){1'b1}}};
`else
   assign w_res = w_res_wrap;
`endif

   assign w_last = (r_cnt == CNT_W'(NDIG - 1));

   // Control FSM and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_a      <= '0;
         r_b      <= '0;
         r_part   <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_ready  <= 1'b1;
         r_done   <= 1'b0;
         r_result <= '0;
         r_c_out  <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b1;
         r_neg    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= mode ? ~b : b;
                  r_carry <= mode;
                  r_cnt   <= '0;
                  r_part  <= '0;
                  r_ready <= 1'b0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_a     <= r_a >> DIGIT;
               r_b     <= r_b >> DIGIT;
               r_carry <= w_sum[DIGIT];
               r_part  <= w_res_wrap[WIDTH-1:DIGIT];
               r_cnt   <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_result <= w_res;
                  r_c_out  <= w_sum[DIGIT];
                  r_ovf    <= w_ovf;
                  r_zero   <= (w_res == '0);
                  r_neg    <= w_res[WIDTH-1];
                  r_done   <= 1'b1;
                  r_ready  <= 1'b1;
                  r_state  <= IDLE;
               end
            end
         endcase
      end
   end

   assign ready     = r_ready;
   assign done      = r_done;
   assign result    = r_result;
   assign c_out     = r_c_out;
   assign over_flow = r_ovf;
   assign zero      = r_zero;
   assign neg       = r_neg;

endmodule

// File: tb/tb_serial_add_sub.sv
// Testbench for serial_add_sub (WIDTH=16, DIGIT=4): directed and random
// operations checked against an integer-arithmetic reference model.

module tb_serial_add_sub;

   localparam int unsigned WIDTH = 16;
   localparam int unsigned DIGIT = 4;
   localparam int unsigned NDIG  = WIDTH / DIGIT;

   logic              clk;
   logic              reset;
   logic              start;
   logic              mode;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic              ready;
   logic              done;
   logic [WIDTH-1:0]  result;
   logic              c_out;
   logic              over_flow;
   logic              zero;
   logic              neg;

   int n_vec = 0;
   int n_err = 0;

   serial_add_sub #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .mode      (mode),
      .a         (a),
      .b         (b),
      .ready     (ready),
      .done      (done),
      .result    (result),
      .c_out     (c_out),
      .over_flow (over_flow),
      .zero      (zero),
      .neg       (neg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: signed/unsigned integer arithmetic -> {result, c_out, over_flow, zero, neg}
   function automatic logic [19:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mm);
      int sa;
      int sb;
      int r;
      logic ovf;
      logic c;
      logic [15:0] res;
      sa  = int'($signed(ma));
      sb  = int'($signed(mb));
      r   = mm ? (sa - sb) : (sa + sb);
      ovf = (r > 32767) || (r < -32768);
      c   = mm ? (ma >= mb) : ((int'(ma) + int'(mb)) > 65535);
      res = 16'(r);
`ifdef SERIAL_ADD_SUB_SAT_EN
      if (ovf) res = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
      return {res, c, ovf, (res == 16'h0000), res[15]};
   endfunction

   // Drives one operation from an idle negedge; garbage and stray starts during RUN.
   // Returns latency in negedges, output snapshot at done, and handshake health.
   task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic im,
                        output int lat, output logic [19:0] obs, output logic hs_ok);
      start = 1'b1; a = ia; b = ib; mode = im;
      lat   = 0;
      hs_ok = 1'b1;
      do begin
         @(negedge clk);
         lat++;
         if (done !== 1'b1) begin
            if (ready !== 1'b0) hs_ok = 1'b0;
            start = 1'($urandom);
            a     = 16'($urandom);
            b     = 16'($urandom);
            mode  = 1'($urandom);
         end
      end while (done !== 1'b1 && lat < 20);
      if (ready !== 1'b1) hs_ok = 1'b0;
      obs   = {result, c_out, over_flow, zero, neg};
      start = 1'b0;
      @(negedge clk);
      if (done !== 1'b0 || {result, c_out, over_flow, zero, neg} !== obs) hs_ok = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({ready, done, result, c_out, over_flow, zero, neg} !== {2'b10, 20'h00002}) begin
         n_err++;
         $display("FAIL reset_values: got ready=%b done=%b out=%h, want ready=1 done=0 out=00002",
                  ready, done, {result, c_out, over_flow, zero, neg});
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        m;
      logic [19:0] e;
   } dvec_t;

   task automatic test_directed();
      dvec_t tbl[6];
      int lat;
      logic [19:0] obs;
      logic hs;
      tbl[0] = '{16'h1234, 16'h0F0F, 1'b0, 20'h21430};
`ifdef SERIAL_ADD_SUB_SAT_EN
      tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 20'h7FFF4};
      tbl[4] = '{16'h8000, 16'h0001, 1'b1, 20'h8000D};
`else
      tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 20'h80005};
      tbl[4] = '{16'h8000, 16'h0001, 1'b1, 20'h7FFFC};
`endif
      tbl[2] = '{16'h0005, 16'h0005, 1'b1, 20'h0000A};
      tbl[3] = '{16'h0003, 16'h0005, 1'b1, 20'hFFFE1};
      tbl[5] = '{16'hFFFF, 16'h0001, 1'b0, 20'h0000A};
      for (int i = 0; i < 6; i++) begin
         do_op(tbl[i].a, tbl[i].b, tbl[i].m, lat, obs, hs);
         n_vec++;
         if (obs !== tbl[i].e || lat != int'(NDIG) + 1 || hs !== 1'b1) begin
            n_err++;
            $display("FAIL directed[%0d]: a=%h b=%h mode=%0d got lat=%0d out=%h hs=%b, want lat=%0d out=%h hs=1",
                     i, tbl[i].a, tbl[i].b, tbl[i].m, lat, obs, hs, NDIG + 1, tbl[i].e);
         end
      end
   endtask

   function automatic logic [15:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 16'h0000;
         1:       return 16'h7FFF;
         2:       return 16'h8000;
         3:       return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic test_random();
      int lat;
      logic [19:0] obs;
      logic [19:0] exp_v;
      logic hs;
      logic [15:0] ra;
      logic [15:0] rb;
      logic rm;
      for (int i = 0; i < 40; i++) begin
         ra = pick_operand();
         rb = pick_operand();
         rm = 1'($urandom);
         exp_v = model(ra, rb, rm);
         do_op(ra, rb, rm, lat, obs, hs);
         n_vec++;
         if (obs !== exp_v || lat != int'(NDIG) + 1 || hs !== 1'b1) begin
            n_err++;
            $display("FAIL random[%0d]: a=%h b=%h mode=%0d got lat=%0d out=%h hs=%b, want lat=%0d out=%h hs=1",
                     i, ra, rb, rm, lat, obs, hs, NDIG + 1, exp_v);
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   // start held high: operands present at every (NDIG+1)-th negedge are the accepted ones.
   task automatic test_back_to_back();
      logic [19:0] q[$];
      logic [19:0] exp_v;
      logic exp_done;
      logic [15:0] ra;
      logic [15:0] rb;
      logic rm;
      localparam int P = NDIG + 1;
      for (int c = 0; c <= 6 * P; c++) begin
         if (c > 0) @(negedge clk);
         exp_done = (c > 0) && (c % P == 0);
         n_vec++;
         if (done !== exp_done) begin
            n_err++;
            $display("FAIL b2b_done cycle %0d: got done=%b, want %b", c, done, exp_done);
         end
         if (exp_done && q.size() > 0) begin
            exp_v = q.pop_front();
            n_vec++;
            if ({ready, result, c_out, over_flow, zero, neg} !== {1'b1, exp_v}) begin
               n_err++;
               $display("FAIL b2b_result cycle %0d: got ready=%b out=%h, want ready=1 out=%h",
                        c, ready, {result, c_out, over_flow, zero, neg}, exp_v);
            end
         end
         ra = pick_operand();
         rb = pick_operand();
         rm = 1'($urandom);
         if (c % P == 0 && c < 6 * P) q.push_back(model(ra, rb, rm));
         start = (c < 6 * P);
         a = ra; b = rb; mode = rm;
      end
      start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      int lat;
      logic [19:0] obs;
      logic hs;
      logic saw_done;
      logic [19:0] exp_v;
      do_op(16'h1234, 16'h0F0F, 1'b0, lat, obs, hs);
      start = 1'b1; a = 16'h4321; b = 16'h1111; mode = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      n_vec++;
      if ({ready, done, result, c_out, over_flow, zero, neg} !== {2'b10, 20'h00002}) begin
         n_err++;
         $display("FAIL midrun_reset: got ready=%b done=%b out=%h, want ready=1 done=0 out=00002",
                  ready, done, {result, c_out, over_flow, zero, neg});
      end
      @(negedge clk);
      reset = 1'b0;
      saw_done = 1'b0;
      repeat (2 * NDIG + 2) begin
         @(negedge clk);
         if (done !== 1'b0) saw_done = 1'b1;
      end
      n_vec++;
      if (saw_done !== 1'b0) begin
         n_err++;
         $display("FAIL midrun_no_done: got stray done=%b, want 0", saw_done);
      end
      exp_v = model(16'hA5C3, 16'h5A3C, 1'b1);
      do_op(16'hA5C3, 16'h5A3C, 1'b1, lat, obs, hs);
      n_vec++;
      if (obs !== exp_v || lat != int'(NDIG) + 1 || hs !== 1'b1) begin
         n_err++;
         $display("FAIL midrun_recover: got lat=%0d out=%h hs=%b, want lat=%0d out=%h hs=1",
                  lat, obs, hs, NDIG + 1, exp_v);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Hard stop so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
